// File: rtl/stream_pkt_reducer.sv
// Packet reducer: pops framed packets (header + L signed words) from an upstream FIFO and
// pushes a 3-word record {header, saturating sum, signed max} into a downstream FIFO.
module stream_pkt_reducer #(
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned LEN_W    = 16
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        flush,
  input  logic [31:0] in_data,
  input  logic        in_empty,
  output logic        in_rden,
  output logic [31:0] out_data,
  input  logic        out_full,
  output logic        out_wren,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StEmit0, StEmit1, StEmit2} state_e;

  state_e             state_q;
  logic               pend_q;
  logic [15:0]        tag_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued_q;
  logic [LEN_W-1:0]   rcvd_q;
  logic [31:0]        word_q;
  logic               word_vld_q;
  logic signed [47:0] acc_q;
  logic signed [31:0] max_q;
  logic [31:0]        out_data_q;

  logic               need_rd;
  logic               emit;
  logic signed [47:0] word_ext;
  logic               word_gt;
  logic               acc_ovf;
  logic [31:0]        sum_out;

  assign need_rd  = (state_q == StIdle) || ((state_q == StPay) && (issued_q != len_q));
  assign emit     = (state_q == StEmit0) || (state_q == StEmit1) || (state_q == StEmit2);
  assign in_rden  = need_rd && !in_empty && !flush;
  assign out_wren = emit && !out_full && !flush;
  assign out_data = out_data_q;
  assign busy     = (state_q != StIdle);

  assign word_ext = {{16{word_q[31]}}, word_q};
  assign word_gt  = $signed(word_q) > max_q;
  // Accumulator fits in signed 32 bits only when bits 47..31 are all copies of the sign.
  assign acc_ovf  = (acc_q[47:31] != {17{acc_q[47]}});

  always_comb begin
    sum_out = acc_q[31:0];
    if (SATURATE && acc_ovf) begin
      sum_out = acc_q[47] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      tag_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      rcvd_q     <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      acc_q      <= '0;
      max_q      <= '0;
      out_data_q <= '0;
    end else if (flush) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      issued_q   <= '0;
      rcvd_q     <= '0;
      word_vld_q <= 1'b0;
      acc_q      <= '0;
      max_q      <= '0;
      out_data_q <= '0;
    end else begin
      pend_q     <= in_rden;
      word_vld_q <= 1'b0;
      // Returned words are staged one cycle before folding into the sum/max.
      if (word_vld_q) begin
        acc_q <= acc_q + word_ext;
        if (word_gt) max_q <= word_q;
      end
      unique case (state_q)
        StIdle: begin
          if (in_rden) state_q <= StHdr;
        end
        StHdr: begin
          tag_q      <= in_data[31:16];
          len_q      <= in_data[LEN_W-1:0];
          issued_q   <= '0;
          rcvd_q     <= '0;
          acc_q      <= '0;
          max_q      <= 32'sh8000_0000;
          out_data_q <= {in_data[31:16], 16'(in_data[LEN_W-1:0])};
          state_q    <= (in_data[LEN_W-1:0] == '0) ? StEmit0 : StPay;
        end
        StPay: begin
          out_data_q <= {tag_q, 16'(len_q)};
          if (in_rden) issued_q <= issued_q + LEN_W'(1);
          if (pend_q) begin
            word_q     <= in_data;
            word_vld_q <= 1'b1;
            rcvd_q     <= rcvd_q + LEN_W'(1);
          end
          // Last word is being folded in on this same edge.
          if (rcvd_q == len_q) state_q <= StEmit0;
        end
        StEmit0: begin
          if (out_wren) begin
            out_data_q <= sum_out;
            state_q    <= StEmit1;
          end
        end
        StEmit1: begin
          if (out_wren) begin
            out_data_q <= max_q;
            state_q    <= StEmit2;
          end
        end
        StEmit2: begin
          if (out_wren) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
